// File: rtl/ppu_palette_out_if.sv
// Purpose : bundles the per-dot pixel stream, the CPU palette port and the
//           frame-buffer write port of the PPU palette/output stage.
// Ports   : no clock or reset here; those stay scalar ports on the module.
//   Pixel stream : pixel, x_idx, scanline, render_en, grayscale (to stage)
//   CPU port     : pal_we, pal_addr, pal_wdata (to stage), pal_rdata (from stage)
//   FB port      : fb_we, fb_addr, fb_data, frame_done (from stage)
//   modport slave  : the palette stage itself
//   modport master : whoever drives dots and CPU accesses and sinks fb writes
interface ppu_palette_out_if;
  // pixel stream from the render/priority stage
  logic [4:0]  pixel;
  logic [9:0]  x_idx;
  logic [9:0]  scanline;
  logic        render_en;
  logic        grayscale;

  // CPU ($2007) palette port
  logic        pal_we;
  logic [4:0]  pal_addr;
  logic [7:0]  pal_wdata;
  logic [7:0]  pal_rdata;

  // frame-buffer write port
  logic        fb_we;
  logic [15:0] fb_addr;
  logic [5:0]  fb_data;
  logic        frame_done;

  modport slave (
    input  pixel, x_idx, scanline, render_en, grayscale,
    input  pal_we, pal_addr, pal_wdata,
    output pal_rdata,
    output fb_we, fb_addr, fb_data, frame_done
  );

  modport master (
    output pixel, x_idx, scanline, render_en, grayscale,
    output pal_we, pal_addr, pal_wdata,
    input  pal_rdata,
    input  fb_we, fb_addr, fb_data, frame_done
  );
endinterface

// File: rtl/ppu_palette_out.sv
// Purpose : resolves the per-dot 5-bit palette address through the 32-entry
//           palette RAM, applies grayscale/render-enable, writes visible dots
//           to the frame buffer; also hosts the CPU palette read/write port.
// Latency : dot at cycle t -> fb_* at t+2; CPU read data 1 cycle after address.
// Backpressure: none; the frame-buffer sink must take one write per cycle.
// Ports:
//   i_clk    - system clock
//   i_reset  - synchronous active-high reset
//   bus      - ppu_palette_out_if.slave (pixel stream, CPU port, FB port)
module ppu_palette_out #(
  parameter int          H_VISIBLE = 256,
  parameter int          V_VISIBLE = 240,
  parameter logic [15:0] FB_BASE   = 16'h0000
) (
  input  logic              i_clk,
  input  logic              i_reset,
  ppu_palette_out_if.slave  bus
);

  localparam logic [9:0] LP_H      = 10'(H_VISIBLE);
  localparam logic [9:0] LP_V      = 10'(V_VISIBLE);
  localparam logic [9:0] LP_H_LAST = 10'(H_VISIBLE - 1);
  localparam logic [9:0] LP_V_LAST = 10'(V_VISIBLE - 1);

  // $10/$14/$18/$1C share storage with $00/$04/$08/$0C.
  function automatic logic [4:0] f_mirror(input logic [4:0] a);
    if (a[4] && (a[1:0] == 2'b00)) begin
      return {1'b0, a[3:0]};
    end
    return a;
  endfunction

  // ------------------------------------------------------------------
  // Palette storage
  // ------------------------------------------------------------------
  logic [5:0] r_pal [32];

  logic [4:0] w_cpu_idx;
  assign w_cpu_idx = f_mirror(bus.pal_addr);

  // Only six colour bits are stored; the top two bits of write data are dropped.
  logic w_unused_wdata;
  assign w_unused_wdata = ^bus.pal_wdata[7:6];

  // Reads below sample r_pal before this edge's update, so a same-cycle
  // write never disturbs a lookup and is itself never lost.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 32; i++) begin
        r_pal[i] <= 6'h00;
      end
    end else if (bus.pal_we) begin
      r_pal[w_cpu_idx] <= bus.pal_wdata[5:0];
    end
  end

  // CPU read: registered every cycle, old data on read-during-write.
  logic [7:0] r_pal_rdata;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pal_rdata <= 8'h00;
    end else begin
      r_pal_rdata <= {2'b00, r_pal[w_cpu_idx]};
    end
  end

  assign bus.pal_rdata = r_pal_rdata;

  // ------------------------------------------------------------------
  // S0: qualify the dot, pick the lookup index, form the fb address
  // ------------------------------------------------------------------
  logic        w_s0_vld;
  logic        w_s0_last;
  logic        w_s0_vblank;
  logic [4:0]  w_s0_idx;
  logic [15:0] w_s0_addr;

  assign w_s0_vld    = (bus.x_idx < LP_H) && (bus.scanline < LP_V);
  assign w_s0_last   = (bus.x_idx == LP_H_LAST) && (bus.scanline == LP_V_LAST);
  assign w_s0_vblank = (bus.scanline >= LP_V);

  // Colour 0 of every sub-palette shows the universal backdrop, and with
  // rendering disabled the whole screen is backdrop.
  always_comb begin
    w_s0_idx = 5'd0;
    if (bus.render_en && (bus.pixel[1:0] != 2'b00)) begin
      w_s0_idx = f_mirror(bus.pixel);
    end
  end

  // Row pitch is 256 regardless of H_VISIBLE, so the address is a concat.
  assign w_s0_addr = {bus.scanline[7:0], bus.x_idx[7:0]} + FB_BASE;

  // ------------------------------------------------------------------
  // S1: palette entry read, dot attributes carried alongside
  // ------------------------------------------------------------------
  logic        r_s1_vld;
  logic        r_s1_last;
  logic        r_s1_gray;
  logic [5:0]  r_s1_entry;
  logic [15:0] r_s1_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_gray  <= 1'b0;
      r_s1_entry <= 6'h00;
      r_s1_addr  <= FB_BASE;
    end else begin
      r_s1_vld   <= w_s0_vld;
      r_s1_last  <= w_s0_last;
      r_s1_gray  <= bus.grayscale;
      r_s1_entry <= r_pal[w_s0_idx];
      r_s1_addr  <= w_s0_addr;
    end
  end

  // ------------------------------------------------------------------
  // frame_done arming
  // ------------------------------------------------------------------
  // Armed out of reset. Firing disarms it; any dot below the visible area
  // re-arms it, so a repeated last dot within one frame cannot pulse twice.
  // The re-arm is listed last: a vblank dot in S0 is newer than the last
  // dot in S1 and must win.
  logic r_armed;
  logic w_fire;

  assign w_fire = r_s1_vld && r_s1_last && r_armed;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_armed <= 1'b1;
    end else begin
      if (w_fire) begin
        r_armed <= 1'b0;
      end
      if (w_s0_vblank) begin
        r_armed <= 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------
  // S2: grayscale and registered frame-buffer write
  // ------------------------------------------------------------------
  logic        r_fb_we;
  logic [15:0] r_fb_addr;
  logic [5:0]  r_fb_data;
  logic        r_frame_done;
  logic [5:0]  w_s1_colour;

  // Grayscale keeps only the luma row of the NES colour grid.
  assign w_s1_colour = r_s1_gray ? (r_s1_entry & 6'h30) : r_s1_entry;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fb_we      <= 1'b0;
      r_fb_addr    <= FB_BASE;
      r_fb_data    <= 6'h00;
      r_frame_done <= 1'b0;
    end else begin
      r_fb_we      <= r_s1_vld;
      r_fb_addr    <= r_s1_addr;
      r_fb_data    <= w_s1_colour;
      r_frame_done <= w_fire;
    end
  end

  assign bus.fb_we      = r_fb_we;
  assign bus.fb_addr    = r_fb_addr;
  assign bus.fb_data    = r_fb_data;
  assign bus.frame_done = r_frame_done;

endmodule
